sdram_burst_responder: RTL

- Responder (target) side of the burst-read port used by the video scan-out initiator: accepts a command, returns BURST_LEN 16-bit words, then waits for the initiator's ACK.
- Converts each burst into single-word reads on a simple pipelined memory backend (BRAM, SDRAM core, or sim model) with in-order, fixed-but-unknown-latency responses.
- Sits between the video controller's SDRAM port and the memory backend.

---
 rtl/sdram_burst_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder
// Target side of the video scan-out burst-read port. Each accepted command is
// split into BURST_LEN single-word reads on a pipelined, in-order memory
// backend. Returned words are forwarded with one register stage. The burst
// then waits for the initiator's ack before the next command is taken.
// Optional feature: define SDRAM_RESP_LAST_EN to add sdram_resp_last, which
// flags the final word of each burst.
module sdram_burst_responder #(
  parameter int BURST_LEN       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sdram_cmd_valid,
  output logic        sdram_cmd_ready,
  input  logic        sdram_rd,
  output logic        sdram_rdy,
  input  logic        sdram_ack,
  input  logic [23:0] sdram_addr_x16,
  output logic        sdram_resp_valid,
  output logic [15:0] sdram_rdata,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [23:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [15:0] mem_rdata_i
`ifdef SDRAM_RESP_LAST_EN
  ,
  output logic        sdram_resp_last
`endif
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LEN_C   = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_C  = CW'(BURST_LEN - 1);
  localparam logic [3:0]    MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT_ACK
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [23:0]   base_q;
  logic [CW-1:0] issue_cnt_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    outstanding_q;
  logic          cmd_fire;
  logic          issue_fire;
  logic          rx_fire;

  // Every command is a read burst, so the direction bit carries no information.
  logic unused_rd;
  assign unused_rd = sdram_rd;

  // Next-state decode plus the handshake outputs, all derived from registered state.
  always_comb begin
    state_d         = state_q;
    cmd_fire        = 1'b0;
    issue_fire      = 1'b0;
    rx_fire         = 1'b0;
    mem_req_o       = 1'b0;
    mem_addr_o      = 24'h000000;
    sdram_cmd_ready = 1'b0;
    sdram_rdy       = 1'b0;
    case (state_q)
      IDLE: begin
        sdram_cmd_ready = 1'b1;
        sdram_rdy       = 1'b1;
        if (sdram_cmd_valid) begin
          cmd_fire = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        mem_addr_o = base_q + 24'(issue_cnt_q);
        mem_req_o  = (issue_cnt_q < LEN_C) && (outstanding_q < MAX_OUT);
        issue_fire = mem_req_o && mem_gnt_i;
        rx_fire    = mem_rvalid_i;
        if (rx_fire && (rx_cnt_q == LAST_C)) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, latched burst base and the issue/receive/in-flight counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      base_q        <= 24'h000000;
      issue_cnt_q   <= '0;
      rx_cnt_q      <= '0;
      outstanding_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        base_q        <= sdram_addr_x16;
        issue_cnt_q   <= '0;
        rx_cnt_q      <= '0;
        outstanding_q <= 4'd0;
      end else begin
        if (issue_fire) begin
          issue_cnt_q <= issue_cnt_q + CW'(1);
        end
        if (rx_fire) begin
          rx_cnt_q <= rx_cnt_q + CW'(1);
        end
        if (issue_fire && !rx_fire) begin
          outstanding_q <= outstanding_q + 4'd1;
        end else if (!issue_fire && rx_fire) begin
          outstanding_q <= outstanding_q - 4'd1;
        end
      end
    end
  end

  // Output register stage for returned words; data outside ACTIVE never reaches the port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sdram_resp_valid <= 1'b0;
      sdram_rdata      <= 16'h0000;
`ifdef SDRAM_RESP_LAST_EN
      sdram_resp_last  <= 1'b0;
`endif
    end else begin
      sdram_resp_valid <= rx_fire;
      if (rx_fire) begin
        sdram_rdata <= mem_rdata_i;
      end
`ifdef SDRAM_RESP_LAST_EN
      sdram_resp_last <= rx_fire && (rx_cnt_q == LAST_C);
`endif
    end
  end

endmodule
